// File: rtl/imem_responder.sv
// Word-organised instruction RAM responder for the fetch request/ready handshake.
// Supports configurable wait states, fetch-redirect aborts, byte-enabled writes and read-after-write bypass.
module imem_responder #(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_err_o
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]        addr_idx_s;
  logic                    accept_s;
  logic                    commit_s;
  logic                    load_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic                    unused_addr_s;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return (idx < DEPTH_IDX);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  assign addr_idx_s    = imem_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_s = ^imem_addr_i[1:0];

  // Next-state logic: accept, wait countdown, and redirect abort.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (imem_valid_i) begin
          accept_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!imem_valid_i) begin
          state_d = S_IDLE;
        end else if (addr_idx_s != idx_q) begin
          accept_s = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (accept_s) begin
      idx_d   = addr_idx_s;
      we_d    = imem_we_i;
      wdata_d = imem_wdata_i;
      if (WAIT_CYCLES == 0) begin
        state_d = S_RESP;
      end else begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // Response data path; a write committing this edge is forwarded into the read.
  always_comb begin
    commit_s  = (state_q == S_RESP) && imem_valid_i && in_range(idx_q) && (we_q != 4'd0);
    load_s    = (state_d == S_RESP);
    rd_word_s = mem_q[idx_d[MEM_AW-1:0]];
    if (commit_s && (idx_d == idx_q)) begin
      rd_word_s = merge_bytes(rd_word_s, wdata_q, we_q);
    end else begin
      rd_word_s = rd_word_s;
    end
    ready_d = load_s;
    if (load_s) begin
      err_d = !in_range(idx_d);
      if ((we_d == 4'd0) && in_range(idx_d)) begin
        rdata_d = rd_word_s;
      end else begin
        rdata_d = {DATA_WIDTH{1'b0}};
      end
    end else begin
      err_d   = err_q;
      rdata_d = rdata_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      we_q    <= 4'd0;
      wdata_q <= {DATA_WIDTH{1'b0}};
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_q[idx_q[MEM_AW-1:0]] <= merge_bytes(mem_q[idx_q[MEM_AW-1:0]], wdata_q, we_q);
    end
  end

  assign imem_ready_o = ready_q;
  assign imem_rdata_o = rdata_q;
  assign imem_err_o   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: vector table and random stream on a zero-wait instance,
// directed multi-cycle sequences on a three-wait-state instance.
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst3 = 1'b1;
  logic        v0 = 1'b0, v3 = 1'b0;
  logic [31:0] a0 = 32'd0, a3 = 32'd0, wd0 = 32'd0, wd3 = 32'd0;
  logic [3:0]  we0 = 4'd0, we3 = 4'd0;
  logic        r0, r3, e0, e3;
  logic [31:0] d0, d3;

  int checks   = 0;
  int failures = 0;

  imem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst0), .imem_valid_i(v0), .imem_ready_o(r0), .imem_addr_i(a0),
    .imem_wdata_i(wd0), .imem_we_i(we0), .imem_rdata_o(d0), .imem_err_o(e0));

  imem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst3), .imem_valid_i(v3), .imem_ready_o(r3), .imem_addr_i(a3),
    .imem_wdata_i(wd3), .imem_we_i(we3), .imem_rdata_o(d3), .imem_err_o(e3));

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        er;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl [20];

  // Transaction-level reference for the zero-wait instance
  logic [31:0] mmem [0:1023];
  logic        pend_v = 1'b0;
  logic [29:0] pend_idx = 30'd0;
  logic [3:0]  pend_we = 4'd0;
  logic [31:0] pend_wd = 32'd0;
  logic [31:0] exp_d = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step0(input logic v, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd, input string name);
    logic [29:0] idx;
    v0 = v; a0 = a; we0 = we; wd0 = wd;
    tick();
    if (pend_v && v && (pend_idx < 30'd1024)) begin
      for (int b = 0; b < 4; b++) begin
        if (pend_we[b]) mmem[pend_idx[9:0]][8*b +: 8] = pend_wd[8*b +: 8];
      end
    end
    idx = a[31:2];
    if (v) begin
      exp_d = ((we == 4'd0) && (idx < 30'd1024)) ? mmem[idx[9:0]] : 32'd0;
      chk({name, " ready"}, {31'd0, r0}, 32'd1);
      chk({name, " err"}, {31'd0, e0}, {31'd0, (idx >= 30'd1024)});
    end else begin
      chk({name, " ready"}, {31'd0, r0}, 32'd0);
    end
    chk({name, " rdata"}, d0, exp_d);
    pend_v = v; pend_idx = idx; pend_we = we; pend_wd = wd;
  endtask

  task automatic req3(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input string name);
    int lat;
    lat = 0;
    v3 = 1'b1; a3 = a; we3 = we; wd3 = wd;
    do begin
      tick();
      lat++;
    end while (!r3 && (lat < 12));
    chk({name, " latency"}, 32'(lat), 32'd4);
    chk({name, " rdata"}, d3, ed);
    chk({name, " err"}, {31'd0, e3}, {31'd0, ee});
  endtask

  task automatic idle3(input logic [31:0] hold, input string name);
    v3 = 1'b0;
    tick();
    chk({name, " ready"}, {31'd0, r3}, 32'd0);
    chk({name, " hold"}, d3, hold);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h0000, 4'hF, 32'h11,       1'b1, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 32'h0004, 4'hF, 32'h22,       1'b1, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 32'h0008, 4'hF, 32'h33,       1'b1, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h000C, 4'hF, 32'h44,       1'b1, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 32'h0000, 4'h0, 32'h0,        1'b1, 32'h11,       1'b0};
    tbl[5]  = '{1'b1, 32'h0004, 4'h0, 32'h0,        1'b1, 32'h22,       1'b0};
    tbl[6]  = '{1'b1, 32'h0008, 4'h0, 32'h0,        1'b1, 32'h33,       1'b0};
    tbl[7]  = '{1'b1, 32'h000C, 4'h0, 32'h0,        1'b1, 32'h44,       1'b0};
    tbl[8]  = '{1'b1, 32'h0008, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 32'h0008, 4'h2, 32'hAABBCCDD, 1'b1, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 32'h0008, 4'h0, 32'h0,        1'b1, 32'h1234CC78, 1'b0};
    tbl[11] = '{1'b1, 32'h1000, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
    tbl[12] = '{1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1};
    tbl[13] = '{1'b1, 32'h0000, 4'h0, 32'h0,        1'b1, 32'h11,       1'b0};
    tbl[14] = '{1'b0, 32'h0000, 4'h0, 32'h0,        1'b0, 32'h11,       1'b0};
    tbl[15] = '{1'b1, 32'h0000, 4'h0, 32'h0,        1'b1, 32'h11,       1'b0};
    tbl[16] = '{1'b1, 32'h0004, 4'hF, 32'h55555555, 1'b1, 32'h0,        1'b0};
    tbl[17] = '{1'b0, 32'h0004, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[18] = '{1'b1, 32'h0004, 4'h0, 32'h0,        1'b1, 32'h22,       1'b0};
    tbl[19] = '{1'b0, 32'h0000, 4'h0, 32'h0,        1'b0, 32'h22,       1'b0};

    // Reset state on both instances
    tick();
    tick();
    chk("rst w0 ready", {31'd0, r0}, 32'd0);
    chk("rst w0 rdata", d0, 32'd0);
    chk("rst w0 err", {31'd0, e0}, 32'd0);
    chk("rst w3 ready", {31'd0, r3}, 32'd0);
    chk("rst w3 rdata", d3, 32'd0);
    chk("rst w3 err", {31'd0, e3}, 32'd0);
    rst0 = 1'b0;
    rst3 = 1'b0;

    for (int i = 0; i < 20; i++) begin
      v0 = tbl[i].v; a0 = tbl[i].a; we0 = tbl[i].we; wd0 = tbl[i].wd;
      tick();
      chk($sformatf("vec%0d ready", i), {31'd0, r0}, {31'd0, tbl[i].er});
      chk($sformatf("vec%0d rdata", i), d0, tbl[i].ed);
      if (tbl[i].er) chk($sformatf("vec%0d err", i), {31'd0, e0}, {31'd0, tbl[i].ee});
    end

    // Random stream against the reference; first give words 0..15 known contents
    exp_d = 32'h22;
    for (int i = 0; i < 16; i++) step0(1'b1, 32'(4 * i), 4'hF, $urandom, "fill");
    step0(1'b1, 32'h0, 4'h0, 32'h0, "fill end");
    for (int i = 0; i < 400; i++) begin
      logic        rv;
      logic [31:0] ra;
      logic [3:0]  rwe;
      logic [3:0]  w;
      rv = ($urandom_range(0, 3) != 0);
      w  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) ra = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      else if ($urandom_range(0, 49) == 0) ra = 32'hFFFF_FFFC;
      else ra = {26'd0, w, 2'($urandom)};
      rwe = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
      step0(rv, ra, rwe, $urandom, "rand");
    end
    step0(1'b0, 32'h0, 4'h0, 32'h0, "rand end");

    // Three wait states: preload, latency and single-cycle ready
    req3(32'h10, 4'hF, 32'hCAFE0004, 32'h0, 1'b0, "w3 wr10");
    req3(32'h40, 4'hF, 32'h0000BEEF, 32'h0, 1'b0, "w3 wr40");
    req3(32'h00, 4'hF, 32'h0BAD0000, 32'h0, 1'b0, "w3 wr00");
    req3(32'h08, 4'hF, 32'h12345678, 32'h0, 1'b0, "w3 wr08");
    req3(32'h10, 4'h0, 32'h0, 32'hCAFE0004, 1'b0, "w3 rd10 pipelined");
    idle3(32'hCAFE0004, "w3 single ready");
    req3(32'h10, 4'h0, 32'h0, 32'hCAFE0004, 1'b0, "w3 rd10 idle");
    idle3(32'hCAFE0004, "w3 after rd10");

    // Redirect one cycle into the wait
    v3 = 1'b1; a3 = 32'h0; we3 = 4'h0;
    tick();
    chk("redirect early ready", {31'd0, r3}, 32'd0);
    req3(32'h40, 4'h0, 32'h0, 32'h0000BEEF, 1'b0, "redirect");
    idle3(32'h0000BEEF, "after redirect");

    // Out of range read and write
    req3(32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, "oor rd");
    req3(32'h1000, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1, "oor wr");
    req3(32'h0000, 4'h0, 32'h0, 32'h0BAD0000, 1'b0, "oor no alias");
    idle3(32'h0BAD0000, "after oor");

    // Valid dropped during the response of a write
    req3(32'h0, 4'hF, 32'h99999999, 32'h0, 1'b0, "drop wr");
    idle3(32'h0, "drop");
    req3(32'h0, 4'h0, 32'h0, 32'h0BAD0000, 1'b0, "drop no commit");
    idle3(32'h0BAD0000, "after drop");

    // Asynchronous reset while ready is high
    req3(32'h10, 4'h0, 32'h0, 32'hCAFE0004, 1'b0, "pre reset");
    #2 rst3 = 1'b1;
    #1;
    chk("async reset ready", {31'd0, r3}, 32'd0);
    chk("async reset rdata", d3, 32'd0);
    v3 = 1'b0;
    tick();
    rst3 = 1'b0;

    // Reset during the wait of a write
    v3 = 1'b1; a3 = 32'h8; we3 = 4'hF; wd3 = 32'hFFFFFFFF;
    tick();
    chk("wr wait ready", {31'd0, r3}, 32'd0);
    tick();
    rst3 = 1'b1;
    #1;
    chk("reset in wait ready", {31'd0, r3}, 32'd0);
    tick();
    tick();
    v3 = 1'b0;
    rst3 = 1'b0;
    tick();
    req3(32'h8, 4'h0, 32'h0, 32'h12345678, 1'b0, "reset no commit");
    idle3(32'h12345678, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
